// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================
// ps2_pkg : shared PS/2 host transmitter constants and helpers
// Rev 1.0
// ============================================================
package ps2_pkg;

    localparam int PS2_FRAME_LEN      = 11;
    localparam int PS2_INHIBIT_CYCLES = 2500;
    localparam int PS2_TIMEOUT_CYCLES = 375000;
    localparam int PS2_FILTER_LEN     = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================
// ps2_line_filter : 2-FF synchronizer, glitch filter, fall strobe
// Rev 1.0
// ============================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q;

    // A new level is accepted only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            fall_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q >= CNT_LAST) begin
                    level_q <= sync_q[1];
                    fall_q  <= level_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================
// ps2_host_tx : PS/2 host-to-device command byte transmitter
// Rev 1.0
// ============================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int               BIT_W    = $clog2(PS2_FRAME_LEN);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [BIT_W-1:0] BIT_PAR  = BIT_W'(8);
    localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(9);

    logic             clk_lvl, clk_fall, data_lvl, data_fall_unused;
    logic [2:0]       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             run;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    assign run = (state_q == S_RTS) || (state_q == S_SHIFT) ||
                 (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bit_d     = bit_q;
        inh_d     = inh_q;
        to_d      = to_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;

        // to_q holds the number of cycles since the last clock fall
        if (run) begin
            if (clk_fall) begin
                to_d = TO_W'(1);
            end else if (to_q != TO_MAX) begin
                to_d = to_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    data_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    inh_d    = '0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q >= INH_LAST) begin
                    state_d   = S_RTS;
                    data_oe_d = 1'b1;
                    bit_d     = '0;
                    to_d      = '0;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            S_RTS: state_d = S_SHIFT;
            S_SHIFT: begin
                if (clk_fall) begin
                    if (bit_q < BIT_PAR) begin
                        data_oe_d = ~data_q[bit_q[2:0]];
                    end else if (bit_q == BIT_PAR) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                    end
                    if (bit_q >= BIT_STOP) begin
                        state_d = S_ACK;
                    end
                    bit_d = bit_q + 1'b1;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    state_d = data_lvl ? S_ERROR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout overrides any clock edge seen in the same cycle
        if (run && (to_q >= TO_LAST)) begin
            state_d   = S_ERROR;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_q     <= '0;
            inh_q     <= '0;
            to_q      <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            bit_q     <= bit_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign tx_error    = (state_q == S_ERROR);
    assign tx_done     = done_q;
    assign ps2_clk_oe  = (state_q == S_INHIBIT);
    assign ps2_data_oe = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================
// tb_ps2_host_tx : device-model bench for ps2_host_tx
// Rev 1.0
// ============================================================
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TO  = 300;
    localparam int FL  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    wire        ps2_clk_line  = dev_clk & ~ps2_clk_oe;
    wire        ps2_data_line = dev_data & ~ps2_data_oe;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_i   (ps2_clk_line),
        .ps2_data_i  (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts completion pulses and records line state around them
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    logic [1:0] pulse_oe = 2'b00;
    logic       ready_after = 1'b0;
    logic       pulse_prev = 1'b0;
    always @(negedge clk) begin
        pulse_prev <= tx_done | tx_error;
        if (pulse_prev) ready_after <= tx_ready;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt <= err_cnt + 1;
        if (tx_done || tx_error) pulse_oe <= {ps2_clk_oe, ps2_data_oe};
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wire-order frame the device should see: data LSB first, odd parity, stop=1
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones;
        ones = $countones(d);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    task automatic accept_and_inhibit(input string nm, input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin step(); n++; end
        tx_data = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check({nm, " clk_oe latency"}, ps2_clk_oe, 1);
        n = 0;
        while (ps2_clk_oe && n < 4 * INH) begin n++; step(); end
        check({nm, " inhibit length"}, n, INH);
        check({nm, " rts data_oe"}, ps2_data_oe, 1);
        repeat (8) step();
    endtask

    task automatic run_frame(input string nm, input logic [7:0] d, input bit ack, input bit glitch,
                             input bit midv, input int half, input logic [9:0] exp_frame,
                             input bit exp_done);
        int n, bd, be;
        logic [9:0] cap;
        bit busy_gap, bad;
        bd = done_cnt;
        be = err_cnt;
        cap = '0;
        busy_gap = 0;
        accept_and_inhibit(nm, d);
        for (int i = 0; i < 11; i++) begin
            dev_clk = 1'b0;
            for (int k = 0; k < half; k++) begin
                if (glitch && i >= 2 && i <= 6) begin
                    if (k == half / 2) dev_clk = 1'b1;
                    else if (k == half / 2 + 2) dev_clk = 1'b0;
                end
                if (midv && i == 4) tx_valid = (k == 3);
                if (i < 10 && (tx_ready || !busy)) busy_gap = 1;
                step();
            end
            if (i < 10) cap[i] = ps2_data_line;
            dev_clk = 1'b1;
            for (int k = 0; k < half; k++) begin
                if (glitch && i >= 2 && i <= 6) begin
                    if (k == half / 2) dev_clk = 1'b0;
                    else if (k == half / 2 + 2) dev_clk = 1'b1;
                end
                if (i == 9 && ack && k == half / 2) dev_data = 1'b0;
                if (i < 10 && (tx_ready || !busy)) busy_gap = 1;
                step();
            end
            if (i == 10) dev_data = 1'b1;
        end
        n = 0;
        while (done_cnt == bd && err_cnt == be && n < 4 * half + 100) begin step(); n++; end
        step();
        step();
        check({nm, " frame bits"}, exp_frame, cap);
        check({nm, " done pulses"}, done_cnt - bd, exp_done ? 1 : 0);
        check({nm, " error pulses"}, err_cnt - be, exp_done ? 0 : 1);
        check({nm, " ready/busy during frame"}, busy_gap, 0);
        check({nm, " lines at pulse"}, pulse_oe, 0);
        check({nm, " ready after pulse"}, ready_after, 1);
        if (midv) begin
            bad = 0;
            repeat (60) begin
                if (ps2_clk_oe || !tx_ready) bad = 1;
                step();
            end
            check({nm, " no second frame"}, bad, 0);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         ack;
        bit         glitch;
        bit         midv;
        logic [9:0] frame;
        bit         done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int bd, be, t0, n;
        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 10'h3ED, 1'b1};
        vecs[1] = '{8'hF4, 1'b1, 1'b0, 1'b1, 10'h2F4, 1'b1};
        vecs[2] = '{8'hED, 1'b0, 1'b0, 1'b0, 10'h3ED, 1'b0};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b0, 10'h35A, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 10'h300, 1'b1};

        repeat (3) step();
        check("reset outputs {clk_oe,data_oe,done,error,busy,ready}",
              {ps2_clk_oe, ps2_data_oe, tx_done, tx_error, busy, tx_ready}, 6'b000001);
        reset_n = 1'b1;
        repeat (4) step();

        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].ack, vecs[i].glitch,
                      vecs[i].midv, 20, vecs[i].frame, vecs[i].done);
        end

        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            bit ack;
            d = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rand%0d", i), d, ack, 1'b0, 1'b0,
                      int'($urandom_range(12, 30)), ref_frame(d), ack);
        end

        // Device stops clocking after bit 3
        bd = done_cnt;
        be = err_cnt;
        t0 = 0;
        accept_and_inhibit("timeout", 8'h03);
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0;
            if (i == 3) t0 = cyc;
            repeat (20) step();
            dev_clk = 1'b1;
            repeat (20) step();
        end
        check("timeout data_oe before abort", ps2_data_oe, 1);
        n = 0;
        while (!tx_error && n < 2 * TO) begin step(); n++; end
        // Filtered fall strobe lags the raw edge by 2 sync stages plus FL samples
        check("timeout latency", cyc - t0, TO + FL + 2);
        check("timeout lines released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        step();
        step();
        check("timeout error pulses", err_cnt - be, 1);
        check("timeout done pulses", done_cnt - bd, 0);

        // Reset asserted mid-frame
        bd = done_cnt;
        be = err_cnt;
        accept_and_inhibit("reset", 8'h00);
        for (int i = 0; i < 2; i++) begin
            dev_clk = 1'b0;
            repeat (20) step();
            dev_clk = 1'b1;
            repeat (20) step();
        end
        check("reset precondition data_oe", ps2_data_oe, 1);
        reset_n = 1'b0;
        #1;
        check("async reset releases lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        dev_clk = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (20) step();
        check("reset no pulses", (done_cnt - bd) + (err_cnt - be), 0);
        run_frame("after reset", 8'hFF, 1'b1, 1'b0, 1'b0, 20, 10'h3FF, 1'b1);

        check("done and error never together", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
